// File: rtl/mem_router_pkg.sv
// mem_router_pkg: shared target/counter types for the memory-request router.
package mem_router_pkg;
    localparam int MAX_SLAVES = 8;
    localparam int TGT_W = $clog2(MAX_SLAVES + 1);
    typedef logic [TGT_W-1:0] tgt_t;
    typedef logic [3:0] cnt_t;
    // The error responder sits one index past the last real slave.
    function automatic tgt_t err_tgt(input int num_slaves);
        return tgt_t'(num_slaves);
    endfunction
endpackage

// File: rtl/mem_router_if.sv
// mem_router_if: core-side memory request/response bus.
interface mem_router_if #(
    parameter int MEM_W = 32
);
    logic req;
    logic gnt;
    logic [31:0] addr;
    logic we;
    logic [MEM_W/8-1:0] be;
    logic [MEM_W-1:0] wdata;
    logic rvalid;
    logic err;
    logic [MEM_W-1:0] rdata;
    modport master(output req, addr, we, be, wdata, input gnt, rvalid, err, rdata);
    modport slave(input req, addr, we, be, wdata, output gnt, rvalid, err, rdata);
endinterface

// File: rtl/mem_addr_decode.sv
// mem_addr_decode: base/mask window match, lowest matching index wins.
module mem_addr_decode
    import mem_router_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES-1:0][31:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES-1:0][31:0] SLAVE_MASK = '0
) (
    input  logic [31:0] addr,
    output tgt_t        tgt,
    output logic        hit
);
    always_comb begin
        tgt = err_tgt(NUM_SLAVES);
        hit = 1'b0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
                tgt = tgt_t'(i);
                hit = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_router.sv
// mem_router: routes one memory master to NUM_SLAVES windows with bounded,
// in-order outstanding requests and an error responder for unmapped addresses.
module mem_router
    import mem_router_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int MEM_W = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter logic [NUM_SLAVES-1:0][31:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES-1:0][31:0] SLAVE_MASK = '0
) (
    input  logic                                clk,
    input  logic                                rst,
    mem_router_if.slave                         m,
    output logic [NUM_SLAVES-1:0]               s_req_o,
    input  logic [NUM_SLAVES-1:0]               s_gnt_i,
    output logic [31:0]                         s_addr_o,
    output logic                                s_we_o,
    output logic [MEM_W/8-1:0]                  s_be_o,
    output logic [MEM_W-1:0]                    s_wdata_o,
    input  logic [NUM_SLAVES-1:0]               s_rvalid_i,
    input  logic [NUM_SLAVES-1:0]               s_err_i,
    input  logic [NUM_SLAVES-1:0][MEM_W-1:0]    s_rdata_i,
    output logic                                spurious_o
);
    tgt_t tgt;
    tgt_t cur_tgt;
    cnt_t out_cnt;
    logic hit;
    logic issue;
    logic accept;
    logic resp;
    logic err_pend;
    logic sel_rvalid;
    logic sel_err;
    logic [MEM_W-1:0] sel_rdata;
    logic [NUM_SLAVES-1:0] own;

    mem_addr_decode #(
        .NUM_SLAVES(NUM_SLAVES),
        .SLAVE_BASE(SLAVE_BASE),
        .SLAVE_MASK(SLAVE_MASK)
    ) u_decode (
        .addr(m.addr),
        .tgt (tgt),
        .hit (hit)
    );

    // Target may only change once every outstanding response has returned.
    assign issue = m.req && out_cnt < cnt_t'(MAX_OUTSTANDING) && (out_cnt == '0 || tgt == cur_tgt);

    always_comb begin
        s_req_o = '0;
        own = '0;
        sel_rvalid = 1'b0;
        sel_err = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            s_req_o[i] = issue && tgt == tgt_t'(i);
            own[i] = out_cnt != '0 && cur_tgt == tgt_t'(i);
            if (own[i]) begin
                sel_rvalid = s_rvalid_i[i];
                sel_err = s_err_i[i];
                sel_rdata = s_rdata_i[i];
            end
        end
    end

    assign m.gnt = hit ? |(s_req_o & s_gnt_i) : issue;
    assign accept = m.req && m.gnt;
    assign resp = err_pend || sel_rvalid;
    assign m.rvalid = resp;
    assign m.err = err_pend || (sel_rvalid && sel_err);
    assign m.rdata = sel_rvalid ? sel_rdata : '0;

    assign s_addr_o = m.addr;
    assign s_we_o = m.we;
    assign s_be_o = m.be;
    assign s_wdata_o = m.wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_cnt <= '0;
            cur_tgt <= '0;
            err_pend <= 1'b0;
            spurious_o <= 1'b0;
        end else begin
            out_cnt <= out_cnt + cnt_t'(accept) - cnt_t'(resp);
            if (accept) cur_tgt <= tgt;
            err_pend <= accept && !hit;
            spurious_o <= |(s_rvalid_i & ~own);
        end
    end
endmodule

// File: tb/tb_mem_router.sv
// tb_mem_router: directed decode table plus multi-cycle sequences for mem_router.
module tb_mem_router;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [3:0] s_req_o, s_gnt_i, s_rvalid_i, s_err_i;
    logic [31:0] s_addr_o;
    logic s_we_o, spurious_o;
    logic [3:0] s_be_o;
    logic [31:0] s_wdata_o;
    logic [3:0][31:0] s_rdata_i;
    int checks = 0;
    int errors = 0;

    localparam logic [3:0][31:0] BASE = {32'h2000_0000, 32'h0000_1000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [3:0][31:0] MASK = {32'hF000_0000, 32'hFFFF_F000, 32'hF000_0000, 32'hF000_0000};

    mem_router_if #(.MEM_W(32)) m_if ();

    mem_router #(
        .NUM_SLAVES(4), .MEM_W(32), .MAX_OUTSTANDING(4),
        .SLAVE_BASE(BASE), .SLAVE_MASK(MASK)
    ) dut (
        .clk(clk), .rst(rst), .m(m_if),
        .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
        .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i),
        .s_err_i(s_err_i), .s_rdata_i(s_rdata_i), .spurious_o(spurious_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0] gnt_in;
        logic [3:0] exp_req;
        logic exp_gnt;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs[8];
        vecs[0] = '{32'h1000_0040, 4'b0010, 4'b0010, 1'b1};
        vecs[1] = '{32'h1000_0040, 4'b0000, 4'b0010, 1'b0};
        vecs[2] = '{32'h0000_1000, 4'b1111, 4'b0001, 1'b1};
        vecs[3] = '{32'h0000_2000, 4'b0001, 4'b0001, 1'b1};
        vecs[4] = '{32'h2000_0004, 4'b0111, 4'b1000, 1'b0};
        vecs[5] = '{32'h2000_0004, 4'b1000, 4'b1000, 1'b1};
        vecs[6] = '{32'h8000_0000, 4'b0000, 4'b0000, 1'b1};
        vecs[7] = '{32'hF000_0000, 4'b1111, 4'b0000, 1'b1};

        m_if.req = 0; m_if.addr = 0; m_if.we = 0; m_if.be = 4'hF; m_if.wdata = 32'h0;
        s_gnt_i = 0; s_rvalid_i = 0; s_err_i = 0; s_rdata_i = '0;

        // reset state
        #2;
        chk("rst_rvalid", m_if.rvalid, 0);
        chk("rst_err", m_if.err, 0);
        chk("rst_rdata", m_if.rdata, 0);
        chk("rst_gnt", m_if.gnt, 0);
        chk("rst_sreq", s_req_o, 0);
        chk("rst_spurious", spurious_o, 0);
        chk("rst_cnt", dut.out_cnt, 0);
        step(); step();
        rst = 1;
        step();

        // decode table, request withdrawn before each edge
        for (int i = 0; i < 8; i++) begin
            m_if.req = 1; m_if.addr = vecs[i].addr; s_gnt_i = vecs[i].gnt_in;
            #1;
            chk($sformatf("vec%0d_sreq", i), s_req_o, vecs[i].exp_req);
            chk($sformatf("vec%0d_gnt", i), m_if.gnt, vecs[i].exp_gnt);
            chk($sformatf("vec%0d_saddr", i), s_addr_o, vecs[i].addr);
            m_if.req = 0;
            step();
        end
        s_gnt_i = 0;

        // single read, slave answers 3 cycles after acceptance
        m_if.req = 1; m_if.addr = 32'h1000_0040; s_gnt_i = 4'b0010;
        #1;
        chk("rd_gnt", m_if.gnt, 1);
        chk("rd_sreq", s_req_o, 4'b0010);
        step();
        m_if.req = 0; s_gnt_i = 0;
        #1;
        chk("rd_wait_rvalid", m_if.rvalid, 0);
        step(); step();
        s_rvalid_i = 4'b0010; s_rdata_i[1] = 32'hDEADBEEF;
        #1;
        chk("rd_rvalid", m_if.rvalid, 1);
        chk("rd_rdata", m_if.rdata, 32'hDEADBEEF);
        chk("rd_err", m_if.err, 0);
        step();
        s_rvalid_i = 0;
        #1;
        chk("rd_cnt", dut.out_cnt, 0);
        chk("rd_spurious", spurious_o, 0);

        // outstanding limit
        m_if.req = 1; m_if.addr = 32'h0000_0100; s_gnt_i = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("lim_gnt%0d", i), m_if.gnt, i < 4);
            step();
        end
        s_rvalid_i = 4'b0001; s_rdata_i[0] = 32'h0000_0011;
        #1;
        chk("lim_full_resp_gnt", m_if.gnt, 0);
        chk("lim_full_rvalid", m_if.rvalid, 1);
        step();
        #1;
        chk("lim_after_resp_gnt", m_if.gnt, 1);
        step();
        s_rvalid_i = 0;
        #1;
        chk("lim_acc_resp_cnt", dut.out_cnt, 3);
        step();
        #1;
        chk("lim_refill_cnt", dut.out_cnt, 4);
        chk("lim_refill_gnt", m_if.gnt, 0);
        m_if.req = 0; s_rvalid_i = 4'b0001;
        for (int i = 0; i < 4; i++) step();
        s_rvalid_i = 0;
        #1;
        chk("lim_drain_cnt", dut.out_cnt, 0);

        // target switch waits for outstanding responses
        m_if.req = 1; m_if.addr = 32'h0000_0200; s_gnt_i = 4'b0011;
        step(); step();
        m_if.addr = 32'h1000_0000;
        #1;
        chk("sw_blk_sreq", s_req_o, 0);
        chk("sw_blk_gnt", m_if.gnt, 0);
        s_rvalid_i = 4'b0001;
        step();
        #1;
        chk("sw_blk2_sreq", s_req_o, 0);
        chk("sw_blk2_gnt", m_if.gnt, 0);
        step();
        s_rvalid_i = 0;
        #1;
        chk("sw_go_sreq", s_req_o, 4'b0010);
        chk("sw_go_gnt", m_if.gnt, 1);
        step();
        m_if.req = 0; s_gnt_i = 0;
        s_rvalid_i = 4'b0011; s_err_i = 4'b0010;
        s_rdata_i[1] = 32'h1234_5678; s_rdata_i[0] = 32'hAAAA_AAAA;
        #1;
        chk("sw_rvalid", m_if.rvalid, 1);
        chk("sw_err", m_if.err, 1);
        chk("sw_rdata", m_if.rdata, 32'h1234_5678);
        step();
        s_rvalid_i = 0; s_err_i = 0;
        #1;
        chk("sw_spurious", spurious_o, 1);
        chk("sw_cnt", dut.out_cnt, 0);

        // unmapped write, back-to-back
        m_if.req = 1; m_if.addr = 32'h8000_0000; m_if.we = 1; m_if.wdata = 32'hCAFE_F00D;
        s_gnt_i = 4'b1111;
        #1;
        chk("um_gnt", m_if.gnt, 1);
        chk("um_sreq", s_req_o, 0);
        chk("um_swdata", s_wdata_o, 32'hCAFE_F00D);
        step();
        #1;
        chk("um_rvalid", m_if.rvalid, 1);
        chk("um_err", m_if.err, 1);
        chk("um_rdata", m_if.rdata, 0);
        chk("um_b2b_gnt", m_if.gnt, 1);
        step();
        m_if.req = 0; m_if.we = 0; s_gnt_i = 0;
        #1;
        chk("um2_rvalid", m_if.rvalid, 1);
        chk("um2_err", m_if.err, 1);
        step();
        #1;
        chk("um_idle_rvalid", m_if.rvalid, 0);
        chk("um_cnt", dut.out_cnt, 0);

        // reset with responses outstanding
        m_if.req = 1; m_if.addr = 32'h1000_0010; s_gnt_i = 4'b0010;
        step(); step();
        m_if.req = 0; s_gnt_i = 0;
        #1;
        chk("mr_cnt_pre", dut.out_cnt, 2);
        rst = 0;
        #1;
        chk("mr_cnt_rst", dut.out_cnt, 0);
        step();
        rst = 1;
        s_rvalid_i = 4'b0010; s_rdata_i[1] = 32'h5555_5555;
        #1;
        chk("mr_rvalid", m_if.rvalid, 0);
        step();
        s_rvalid_i = 0;
        #1;
        chk("mr_spurious", spurious_o, 1);
        step();
        chk("mr_spurious_once", spurious_o, 0);
        chk("mr_cnt", dut.out_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
